// File: rtl/mux_scan_seq.sv
// Byte serializer front-end for the 8:1 enabled bit-select mux: latches a word,
// then walks the select across all eight positions, DIV clocks per position.
module mux_scan_seq #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       msb_first,
  input  logic       abort,
  output logic [7:0] a,
  output logic       en,
  output logic [2:0] s,
  output logic       busy,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic [2:0]    s_q, s_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_pos;

  // Final position depends on the direction latched with the word.
  assign last_pos = dir_q ? (s_q == 3'd0) : (s_q == 3'd7);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          a_d     = din;
          dir_d   = msb_first;
          s_d     = msb_first ? 3'd7 : 3'd0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (last_pos) begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            s_d = dir_q ? (s_q - 3'd1) : (s_q + 3'd1);
          end
        end
      end
      DONE: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      s_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a    = a_q;
  assign s    = s_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: one instance at DIV=4, one at DIV=1.
module tb_mux_scan_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic [7:0] din;
  logic       msb_first;
  logic       abort;

  logic [7:0] a4, a1;
  logic       en4, en1, busy4, busy1, done4, done1;
  logic [2:0] s4, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan_seq #(.DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start4), .din(din), .msb_first(msb_first),
    .abort(abort), .a(a4), .en(en4), .s(s4), .busy(busy4), .done(done4)
  );

  mux_scan_seq #(.DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start1), .din(din), .msb_first(msb_first),
    .abort(abort), .a(a1), .en(en1), .s(s1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] seq_a5;
  logic [7:0] seq_3c;
  int en_cnt, done_cnt;

  initial begin
    // mux output bit at successive positions, written by hand from the words
    seq_a5 = 8'b1010_0101; // position k -> seq_a5[7-k]: 1,0,1,0,0,1,0,1
    seq_3c = 8'b0011_1100; // position k -> seq_3c[7-k]: 0,0,1,1,1,1,0,0
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; din = 8'h00; msb_first = 1'b0; abort = 1'b0;
    #1;
    chk("rst_en",   {31'd0, en4},   32'd0);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_s",    {29'd0, s4},    32'd0);
    chk("rst_a",    {24'd0, a4},    32'd0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_en", {31'd0, en4 | busy4 | done4}, 32'd0);
    end
    chk("idle_s_a", {21'd0, s4, a4}, 32'd0);

    // LSB-first word at DIV=4
    din = 8'hA5; msb_first = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0; din = 8'h00;
    for (int k = 0; k < 32; k++) begin
      chk("lsb_en",   {30'd0, en4, busy4}, 32'd3);
      chk("lsb_s",    {29'd0, s4}, k / 4);
      chk("lsb_bit",  {31'd0, a4[s4]}, {31'd0, seq_a5[7 - k / 4]});
      chk("lsb_done", {31'd0, done4}, 32'd0);
      tick();
    end
    chk("lsb_end_en",  {30'd0, en4, busy4}, 32'd0);
    chk("lsb_end_done", {31'd0, done4}, 32'd1);
    tick();
    chk("lsb_done_clr", {31'd0, done4}, 32'd0);
    chk("lsb_a_hold",   {24'd0, a4}, 32'hA5);

    // MSB-first word at DIV=1
    din = 8'h3C; msb_first = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0; msb_first = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("msb_en",  {31'd0, en1}, 32'd1);
      chk("msb_s",   {29'd0, s1}, 7 - k);
      chk("msb_bit", {31'd0, a1[s1]}, {31'd0, seq_3c[7 - k]});
      tick();
    end
    chk("msb_done",   {30'd0, en1, done1}, 32'd1);
    tick();
    chk("msb_done_clr", {31'd0, done1}, 32'd0);

    // start/din changes while busy are ignored
    din = 8'h0F; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(2);
    din = 8'hF0; start4 = 1'b1;
    tick(4);
    chk("busy_a",   {24'd0, a4}, 32'h0F);
    chk("busy_s",   {29'd0, s4}, 32'd1);
    tick(26);
    chk("busy_done", {31'd0, done4}, 32'd1);
    chk("busy_a_end", {24'd0, a4}, 32'h0F);
    tick();
    chk("done_start_ign", {30'd0, en4, busy4}, 32'd0);
    tick();
    chk("restart_en", {30'd0, en4, busy4}, 32'd3);
    chk("restart_a",  {24'd0, a4}, 32'hF0);
    start4 = 1'b0;

    // abort at s=3, div_cnt=2
    tick(14);
    chk("pre_abort_s", {29'd0, s4}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_en",   {30'd0, en4, busy4}, 32'd0);
    chk("abort_done", {31'd0, done4}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      done_cnt += int'(done4);
    end
    chk("abort_no_done", done_cnt, 32'd0);

    din = 8'h81; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("post_abort_a", {24'd0, a4}, 32'h81);
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      en_cnt   += int'(en4);
      done_cnt += int'(done4);
      tick();
    end
    chk("post_abort_en_len", en_cnt, 32'd32);
    chk("post_abort_done",   done_cnt, 32'd1);

    // async reset between edges mid-word
    din = 8'h5A; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_en_busy", {30'd0, en4, busy4}, 32'd0);
    chk("arst_s",       {29'd0, s4}, 32'd0);
    chk("arst_a",       {24'd0, a4}, 32'd0);
    #1 rst = 1'b0;
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      en_cnt   += int'(en4);
      done_cnt += int'(done4);
    end
    chk("arst_no_en",   en_cnt, 32'd0);
    chk("arst_no_done", done_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
